// File: rtl/data_mem_lsu.sv
// Word-organised data memory behind a load/store front end.
// One request in flight; the response appears after LATENCY cycles and waits for rsp_ready.
module data_mem_lsu #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] CNT_LAST = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [1:0]  cnt_q;
    logic [31:0] res_q;
    logic        res_err_q;

    logic [31:0] mem_q [DEPTH];

    logic        accept;
    logic [1:0]  off;
    logic        size_bad;
    logic        mis_half;
    logic        mis_word;
    logic        out_of_range;
    logic        err_d;
    logic [AW-1:0] widx;
    logic [3:0]  be_d;
    logic [31:0] wlanes_d;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] load_d;
    logic [31:0] res_d;

    assign accept = req_valid && req_ready_q && !reset;
    assign off    = req_addr[1:0];
    assign widx   = req_addr[AW+1:2];

    assign size_bad     = (req_size == 2'b11);
    assign mis_half     = (req_size == 2'b01) && off[0];
    assign mis_word     = (req_size == 2'b10) && (off != 2'b00);
    assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DEPTH);
    assign err_d        = size_bad || mis_half || mis_word || out_of_range;

    always_comb begin
        be_d = 4'b0000;
        unique case (req_size)
            2'b00:   be_d = 4'b0001 << off;
            2'b01:   be_d = 4'b0011 << off;
            2'b10:   be_d = 4'b1111;
            default: be_d = 4'b0000;
        endcase
    end

    assign wlanes_d = req_wdata << {off, 3'b000};

    // Memory array carries no reset; only committed stores change it.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) begin
                    mem_q[widx][8*i +: 8] <= wlanes_d[8*i +: 8];
                end
            end
        end
    end

    assign rword  = mem_q[widx];
    assign rshift = rword >> {off, 3'b000};

    always_comb begin
        load_d = rword;
        unique case (req_size)
            2'b00: begin
                if (req_unsigned) load_d = {24'h0, rshift[7:0]};
                else              load_d = {{24{rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                if (req_unsigned) load_d = {16'h0, rshift[15:0]};
                else              load_d = {{16{rshift[15]}}, rshift[15:0]};
            end
            default: load_d = rword;
        endcase
    end

    assign res_d = (err_d || req_we) ? 32'h0 : load_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 2'd0;
            res_q       <= 32'h0;
            res_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        res_q       <= res_d;
                        res_err_q   <= err_d;
                        cnt_q       <= 2'd0;
                        req_ready_q <= 1'b0;
                        if (LATENCY > 1) begin
                            state_q <= WAIT;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= res_d;
                            rsp_err_q   <= err_d;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= res_q;
                        rsp_err_q   <= res_err_q;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one LATENCY=1 and one LATENCY=3 instance against a byte-array model.
// Directed vector table, hand-written multi-cycle sequences, then random traffic.
module tb_data_mem_lsu;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        rdy1, vld1, err1;
    logic [31:0] rdata1;
    logic        rdy3, vld3, err3;
    logic [31:0] rdata3;

    logic        rdy, vld, err;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mref [2][4*DEPTH];

    data_mem_lsu #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid && !sel),
        .req_ready    (rdy1),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (vld1),
        .rsp_ready    (rsp_ready && !sel),
        .rsp_rdata    (rdata1),
        .rsp_err      (err1)
    );

    data_mem_lsu #(.DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid && sel),
        .req_ready    (rdy3),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (vld3),
        .rsp_ready    (rsp_ready && sel),
        .rsp_rdata    (rdata3),
        .rsp_err      (err3)
    );

    assign rdy   = sel ? rdy3 : rdy1;
    assign vld   = sel ? vld3 : vld1;
    assign err   = sel ? err3 : err1;
    assign rdata = sel ? rdata3 : rdata1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (dut lat%0d)", name, act, exp, sel ? 3 : 1);
        end
    endtask

    // Reference behaviour: byte-addressed array, plain arithmetic.
    task automatic ref_op(input bit s, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit e);
        int n;
        logic [31:0] v;
        n  = 1 << size;
        e  = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
             (size == 2'd2 && a % 4 != 0) || (a / 4 >= DEPTH);
        rd = 32'h0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) mref[s][a + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mref[s][a + i]) << (8 * i));
                if (!uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endtask

    task automatic txn(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold, input bit early,
                       output logic [31:0] rd, output bit e);
        int k;
        int lat;
        bit busy_ok;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        rsp_ready    = early;
        k = 0;
        while (!rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_idle", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!vld && lat < 20) begin
            if (rdy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), sel ? 32'd3 : 32'd1);
        chk("ready_low_wait", 32'(busy_ok), 32'd1);
        chk("ready_low_resp", 32'(rdy), 32'd0);
        rd = rdata;
        e  = err;
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk("hold_valid", {rdy, vld}, 32'b01);
                chk("hold_rdata", rdata, rd);
                chk("hold_err", 32'(err), 32'(e));
            end
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("released", {rdy, vld}, 32'b10);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tab[16];

    initial begin
        logic [31:0] rd, mrd;
        bit e, me;
        int vld_seen;

        tab[0]  = '{1, 2'd2, 0, 32'h010, 32'hDEADBEEF, 32'h0, 0};
        tab[1]  = '{0, 2'd2, 0, 32'h010, 32'h0, 32'hDEADBEEF, 0};
        tab[2]  = '{1, 2'd0, 0, 32'h011, 32'h7F, 32'h0, 0};
        tab[3]  = '{0, 2'd2, 0, 32'h010, 32'h0, 32'hDEAD7FEF, 0};
        tab[4]  = '{0, 2'd0, 0, 32'h013, 32'h0, 32'hFFFFFFDE, 0};
        tab[5]  = '{0, 2'd0, 1, 32'h013, 32'h0, 32'h000000DE, 0};
        tab[6]  = '{1, 2'd2, 0, 32'h020, 32'h11223344, 32'h0, 0};
        tab[7]  = '{1, 2'd1, 0, 32'h022, 32'h8001, 32'h0, 0};
        tab[8]  = '{0, 2'd1, 0, 32'h022, 32'h0, 32'hFFFF8001, 0};
        tab[9]  = '{0, 2'd1, 1, 32'h022, 32'h0, 32'h00008001, 0};
        tab[10] = '{1, 2'd1, 0, 32'h021, 32'hAAAA, 32'h0, 1};
        tab[11] = '{0, 2'd2, 0, 32'h020, 32'h0, 32'h80013344, 0};
        tab[12] = '{1, 2'd2, 0, 32'h3FC, 32'hCAFEF00D, 32'h0, 0};
        tab[13] = '{0, 2'd2, 0, 32'h3FC, 32'h0, 32'hCAFEF00D, 0};
        tab[14] = '{0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 1};
        tab[15] = '{0, 2'd3, 0, 32'h000, 32'h0, 32'h0, 1};

        sel = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_ready", 32'(rdy), 32'd1);
            chk("reset_valid", 32'(vld), 32'd0);
            chk("reset_rdata", rdata, 32'h0);
            chk("reset_err", 32'(err), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < DEPTH; w++) begin
                logic [31:0] d;
                d = $urandom;
                ref_op(sel, 1, 2'd2, 0, 32'(4 * w), d, mrd, me);
                txn(1, 2'd2, 0, 32'(4 * w), d, 0, 0, rd, e);
                if (w % 64 == 0) begin
                    chk("init_rdata", rd, 32'h0);
                    chk("init_err", 32'(e), 32'd0);
                end
            end
        end

        sel = 1'b0;
        foreach (tab[i]) begin
            ref_op(sel, tab[i].we, tab[i].size, tab[i].uns, tab[i].addr, tab[i].wdata, mrd, me);
            txn(tab[i].we, tab[i].size, tab[i].uns, tab[i].addr, tab[i].wdata, i % 3, 0, rd, e);
            chk($sformatf("tab%0d_rdata", i), rd, tab[i].exp_rd);
            chk($sformatf("tab%0d_err", i), 32'(e), 32'(tab[i].exp_err));
        end

        sel = 1'b1;
        ref_op(sel, 1, 2'd2, 0, 32'h80, 32'h13579BDF, mrd, me);
        txn(1, 2'd2, 0, 32'h80, 32'h13579BDF, 0, 0, rd, e);
        txn(0, 2'd2, 0, 32'h80, 32'h0, 5, 0, rd, e);
        chk("lat3_hold_rdata", rd, 32'h13579BDF);
        txn(0, 2'd0, 0, 32'h81, 32'h0, 0, 1, rd, e);
        chk("lat3_early_ready", rd, 32'hFFFFFF9B);

        @(negedge clk);
        req_we = 1'b1;
        req_size = 2'd2;
        req_addr = 32'h40;
        req_wdata = 32'h5A5AA5A5;
        req_valid = 1'b1;
        ref_op(sel, 1, 2'd2, 0, 32'h40, 32'h5A5AA5A5, mrd, me);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vld_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (vld) vld_seen++;
        end
        chk("reset_drop_valid", 32'(vld_seen), 32'd0);
        chk("reset_drop_ready", 32'(rdy), 32'd1);
        txn(0, 2'd2, 0, 32'h40, 32'h0, 0, 0, rd, e);
        chk("reset_store_kept", rd, 32'h5A5AA5A5);
        chk("reset_store_err", 32'(e), 32'd0);

        for (int it = 0; it < 400; it++) begin
            bit we, uns, early;
            logic [1:0] size;
            logic [31:0] a, wd;
            int pick;
            sel = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            early = ($urandom_range(0, 3) == 0);
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            pick = $urandom_range(0, 19);
            if (pick == 0)      a = 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            else if (pick == 1) a = $urandom;
            else                a = 32'($urandom_range(0, 4 * DEPTH - 1));
            if (pick > 5 && size != 2'd0) a = a & ~32'((1 << size) - 1);
            wd = $urandom;
            ref_op(sel, we, size, uns, a, wd, mrd, me);
            txn(we, size, uns, a, wd, $urandom_range(0, 3), early, rd, e);
            chk("rand_rdata", rd, mrd);
            chk("rand_err", 32'(e), 32'(me));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
